prog_dump: RTL and testbench
============================

// Module: prog_dump
// PURPOSE
// - Read-back transmitter for program memory: on request, reads prog RAM as 32-bit words and
//   pushes the bytes, little-endian, into the UART TX FIFO, followed by an 8-bit checksum.
// - Sits beside programmer in rv32i SoC, sharing prog RAM read port and UART TX path while core is
//   held (progEn=1); lets the host verify a download byte-for-byte.
// PARAMETERS
// - MEM_SIZE  32767  program memory size in bytes; INSTRW = $clog2(MEM_SIZE)
// - XLEN      32     memory read data width (fixed 32; other values unsupported)
// PORTS
// - clk        in   1         clock
// - rstB       in   1         reset, synchronous, active-low
// - dumpStart  in   1         one-cycle start pulse; ignored while busy=1
// - dumpLen    in   INSTRW+1  number of bytes to dump, sampled on accepted dumpStart
// - memAddr    out  INSTRW    byte address to prog RAM, always word-aligned ([1:0]=0)
// - memRdEn    out  1         read strobe; memData valid the cycle after
// - memData    in   XLEN      prog RAM read data
// - txFfFull   in   1         UART TX FIFO full
// - txWrEn     out  1         TX FIFO write strobe, asserted only when txFfFull=0
// - txData     out  8         byte to TX FIFO, valid with txWrEn
// - busy       out  1         dump in progress (START accepted .. DONE)
// - done       out  1         one-cycle pulse after checksum byte written
// BEHAVIOUR
// - Reset (rstB=0 at posedge): state IDLE; memAddr=0, memRdEn=0, txWrEn=0, txData=0, busy=0,
//   done=0, byte counter=0, checksum=0. Reset mid-dump aborts immediately; no partial byte sent.
// - Length latch: len = min(dumpLen, MEM_SIZE); checksum cleared; byte counter cnt cleared.
// - States:
//   IDLE : dumpStart -> latch len; len==0 ? CSUM : RD_REQ. busy=1 from next cycle.
//   RD_REQ: memRdEn=1 for one cycle, memAddr={cnt[INSTRW-1:2],2'b00} -> RD_WAIT.
//   RD_WAIT: capture memData into word buffer wb; byte index bi=cnt[1:0] -> SEND.
//   SEND : if !txFfFull: txWrEn=1, txData=wb[8*bi+:8], chk+=txData (mod 256), cnt++, bi++.
//          after write: cnt==len -> CSUM; else bi wrapped to 0 -> RD_REQ; else stay SEND.
//          txFfFull=1 -> hold, txWrEn=0, no counter change.
//   CSUM : if !txFfFull: txWrEn=1, txData=chk (sum of all dumped bytes mod 256) -> DONE.
//   DONE : done=1 one cycle, busy=0 -> IDLE.
// - Latency: first txWrEn no earlier than 3 cycles after accepted dumpStart (IDLE, RD_REQ,
//   RD_WAIT); then 1 byte/cycle while FIFO not full; 2 extra cycles per word refill.
// - Partial last word: len not multiple of 4 -> only the remaining bytes of last word sent.
// - len==MEM_SIZE with MEM_SIZE not multiple of 4: last word read at address MEM_SIZE&~3; only
//   in-range bytes sent. memAddr never exceeds MEM_SIZE-1.
// - dumpStart while busy: ignored, no restart, dumpLen not resampled.
// - txWrEn and txFfFull rising same cycle: FIFO sampled combinationally; txWrEn never high
//   with txFfFull=1.
// - memRdEn/memAddr are registered; top-level mux selects prog_dump vs programmer vs core PC.
// STRUCTURE
// - Shared package rv32i_soc_pkg: typedef enum logic[2:0] dump_state_t {IDLE,RD_REQ,RD_WAIT,
//   SEND,CSUM,DONE}; UART register address constants (UDR 11'h402, UCR 11'h403).
// - Single module, no sub-modules; byte select is a plain mux on wb.
// TESTING
// - Model prog RAM preloaded 0x03020100,0x07060504; dumpLen=8, txFfFull=0 -> txData 00..07 in
//   order, then checksum 0x1C; done pulses once; busy low after.
// - Same memory, dumpLen=5 -> bytes 00,01,02,03,04 then checksum 0x0A; exactly 2 memRdEn pulses.
// - dumpLen=0 -> single txWrEn with txData=0x00, no memRdEn, done pulse.
// - dumpLen=8, txFfFull toggled 1/0 every 2 cycles -> same byte stream, txWrEn never with
//   txFfFull=1, no duplicates or drops.
// - dumpStart re-pulsed mid-dump with dumpLen=2 -> ignored; full 8-byte stream + 0x1C completes.
// - rstB low for 1 cycle after 3rd byte -> all outputs zero next cycle, IDLE; new dumpStart
//   with dumpLen=4 -> 00..03 then checksum 0x06.

Source files
------------

// File: rtl/rv32i_soc_pkg.sv
// Shared rv32i SoC definitions: program-dump FSM states, UART register addresses
// and the little-endian byte picker used on prog RAM words.
package rv32i_soc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    SEND,
    CSUM,
    DONE
  } dump_state_t;

  localparam logic [10:0] UDR = 11'h402;
  localparam logic [10:0] UCR = 11'h403;

  // Byte idx of a 32-bit word, little-endian (idx 0 is the lowest address)
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/prog_dump.sv
// Program memory read-back: streams prog RAM bytes little-endian into the UART TX FIFO,
// followed by an 8-bit additive checksum of everything sent.
import rv32i_soc_pkg::*;

module prog_dump #(
  parameter int MEM_SIZE = 32767,
  parameter int XLEN = 32,
  localparam int INSTRW = $clog2(MEM_SIZE)
) (
  input  logic              clk,
  input  logic              rstB,
  input  logic              dumpStart,
  input  logic [INSTRW:0]   dumpLen,
  output logic [INSTRW-1:0] memAddr,
  output logic              memRdEn,
  input  logic [XLEN-1:0]   memData,
  input  logic              txFfFull,
  output logic              txWrEn,
  output logic [7:0]        txData,
  output logic              busy,
  output logic              done
);

  localparam logic [INSTRW:0] MAX_LEN = (INSTRW+1)'(MEM_SIZE);

  dump_state_t      state;
  logic [INSTRW:0]  len;
  logic [INSTRW:0]  cnt;
  logic [INSTRW:0]  cnt_inc;
  logic [XLEN-1:0]  wb;
  logic [7:0]       chk;
  logic [7:0]       cur_byte;

  assign cnt_inc  = cnt + (INSTRW+1)'(1);
  assign cur_byte = byte_sel(wb, cnt[1:0]);

  // The FIFO full flag gates the write strobe combinationally so a write can never
  // land on a FIFO that filled up in the same cycle.
  assign txWrEn = !txFfFull && ((state == SEND) || (state == CSUM));

  always_comb begin
    txData = 8'h00;
    if (state == SEND)
      txData = cur_byte;
    else if (state == CSUM)
      txData = chk;
  end

  always_ff @(posedge clk) begin
    if (!rstB) begin
      state   <= IDLE;
      memAddr <= '0;
      memRdEn <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      len     <= '0;
      cnt     <= '0;
      chk     <= 8'h00;
      wb      <= '0;
    end else begin
      memRdEn <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (dumpStart) begin
            len  <= (dumpLen > MAX_LEN) ? MAX_LEN : dumpLen;
            cnt  <= '0;
            chk  <= 8'h00;
            busy <= 1'b1;
            if (dumpLen == '0) begin
              state <= CSUM;
            end else begin
              state   <= RD_REQ;
              memRdEn <= 1'b1;
              memAddr <= '0;
            end
          end
        end
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: begin
          wb    <= memData;
          state <= SEND;
        end
        SEND: begin
          if (!txFfFull) begin
            chk <= chk + cur_byte;
            cnt <= cnt_inc;
            if (cnt_inc == len) begin
              state <= CSUM;
            end else if (cnt[1:0] == 2'b11) begin
              // Word exhausted: fetch the next one; the address stays below MEM_SIZE
              // because cnt_inc < len <= MEM_SIZE.
              state   <= RD_REQ;
              memRdEn <= 1'b1;
              memAddr <= {cnt_inc[INSTRW-1:2], 2'b00};
            end
          end
        end
        CSUM: begin
          if (!txFfFull) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_dump.sv
// Self-checking bench for prog_dump: table vectors, hand-written restart/reset sequences
// and randomized dumps checked against a byte-array model of prog RAM.
module tb_prog_dump;

  localparam int MEM_SIZE = 32767;
  localparam int INSTRW = $clog2(MEM_SIZE);
  localparam int NWORDS = (MEM_SIZE + 3) / 4;

  logic              clk = 1'b0;
  logic              rstB;
  logic              dumpStart;
  logic [INSTRW:0]   dumpLen;
  logic [INSTRW-1:0] memAddr;
  logic              memRdEn;
  logic [31:0]       memData;
  logic              txFfFull;
  logic              txWrEn;
  logic [7:0]        txData;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  prog_dump #(.MEM_SIZE(MEM_SIZE), .XLEN(32)) dut (
    .clk(clk),
    .rstB(rstB),
    .dumpStart(dumpStart),
    .dumpLen(dumpLen),
    .memAddr(memAddr),
    .memRdEn(memRdEn),
    .memData(memData),
    .txFfFull(txFfFull),
    .txWrEn(txWrEn),
    .txData(txData),
    .busy(busy),
    .done(done)
  );

  logic [31:0] ram [0:NWORDS-1];

  always @(posedge clk)
    if (memRdEn) memData <= ram[memAddr[INSTRW-1:2]];

  // Passive monitor; the main sequence only reads these, working with deltas.
  logic [7:0] got_q[$];
  int rd_cnt = 0;
  int done_cnt = 0;
  int viol_cnt = 0;
  int addr_bad = 0;

  always @(negedge clk) begin
    if (txWrEn) got_q.push_back(txData);
    if (txWrEn && txFfFull) viol_cnt++;
    if (memRdEn) begin
      rd_cnt++;
      if (memAddr[1:0] != 2'b00 || int'(memAddr) > MEM_SIZE - 1) addr_bad++;
    end
    if (done) done_cnt++;
  end

  int full_mode = 0;
  int phase = 0;

  initial begin
    txFfFull = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      phase++;
      case (full_mode)
        1:       txFfFull = phase[1];
        2:       txFfFull = ($urandom_range(0, 2) == 0);
        default: txFfFull = 1'b0;
      endcase
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  int exp_rd;
  int base_got, base_rd, base_done, base_viol, base_addr;

  typedef struct {
    logic [INSTRW:0] len;
    int              mode;
    logic [7:0]      chk;
    int              rd;
  } vec_t;

  vec_t vecs[4];

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: the first min(len, MEM_SIZE) bytes of memory, then their sum mod 256.
  task automatic build_expected(input int req_len);
    int n;
    int sum;
    logic [7:0] b;
    n = (req_len > MEM_SIZE) ? MEM_SIZE : req_len;
    exp_q.delete();
    sum = 0;
    for (int i = 0; i < n; i++) begin
      b = 8'(ram[i / 4] >> (8 * (i % 4)));
      exp_q.push_back(b);
      sum += int'(b);
    end
    exp_q.push_back(8'(sum % 256));
    exp_rd = (n + 3) / 4;
  endtask

  task automatic snapshot();
    base_got  = got_q.size();
    base_rd   = rd_cnt;
    base_done = done_cnt;
    base_viol = viol_cnt;
    base_addr = addr_bad;
  endtask

  task automatic applyStimulus(input logic [INSTRW:0] l);
    @(posedge clk);
    #1;
    dumpStart = 1'b1;
    dumpLen = l;
    @(posedge clk);
    #1;
    dumpStart = 1'b0;
    checkOutput("busy_after_start", int'(busy), 1);
  endtask

  task automatic finish_dump(input string tag, input int budget);
    int waited;
    bit seen;
    int ngot;
    int nchk;
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < budget) begin
      @(negedge clk);
      waited++;
      if (done) seen = 1'b1;
    end
    checkOutput({tag, " done_reached"}, int'(seen), 1);
    @(negedge clk);
    checkOutput({tag, " busy_after_done"}, int'(busy), 0);
    checkOutput({tag, " done_single_cycle"}, int'(done), 0);
    checkOutput({tag, " done_pulses"}, done_cnt - base_done, 1);
    ngot = got_q.size() - base_got;
    checkOutput({tag, " byte_count"}, ngot, exp_q.size());
    nchk = (ngot < exp_q.size()) ? ngot : exp_q.size();
    for (int i = 0; i < nchk; i++)
      checkOutput($sformatf("%s byte%0d", tag, i), int'(got_q[base_got + i]), int'(exp_q[i]));
    checkOutput({tag, " rd_pulses"}, rd_cnt - base_rd, exp_rd);
    checkOutput({tag, " wr_while_full"}, viol_cnt - base_viol, 0);
    checkOutput({tag, " bad_addr"}, addr_bad - base_addr, 0);
  endtask

  initial begin
    int seen;
    int waited;
    int rlen;

    vecs[0] = '{(INSTRW+1)'(8), 0, 8'h1C, 2};
    vecs[1] = '{(INSTRW+1)'(5), 0, 8'h0A, 2};
    vecs[2] = '{(INSTRW+1)'(0), 0, 8'h00, 0};
    vecs[3] = '{(INSTRW+1)'(8), 1, 8'h1C, 2};

    for (int i = 0; i < NWORDS; i++) ram[i] = 32'h0;
    ram[0] = 32'h03020100;
    ram[1] = 32'h07060504;

    rstB = 1'b0;
    dumpStart = 1'b0;
    dumpLen = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset memAddr", int'(memAddr), 0);
    checkOutput("reset memRdEn", int'(memRdEn), 0);
    checkOutput("reset txWrEn", int'(txWrEn), 0);
    checkOutput("reset txData", int'(txData), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    @(posedge clk);
    #1;
    rstB = 1'b1;

    for (int k = 0; k < 4; k++) begin
      full_mode = vecs[k].mode;
      build_expected(int'(vecs[k].len));
      exp_rd = vecs[k].rd;
      snapshot();
      applyStimulus(vecs[k].len);
      finish_dump($sformatf("vec%0d", k), 200);
      if (got_q.size() > base_got)
        checkOutput($sformatf("vec%0d chk_table", k), int'(got_q[got_q.size() - 1]),
                    int'(vecs[k].chk));
    end
    full_mode = 0;

    // Second start while busy must neither restart nor resample the length.
    build_expected(8);
    snapshot();
    applyStimulus((INSTRW+1)'(8));
    repeat (3) @(posedge clk);
    #1;
    dumpStart = 1'b1;
    dumpLen = (INSTRW+1)'(2);
    @(posedge clk);
    #1;
    dumpStart = 1'b0;
    finish_dump("restart", 200);

    // Reset right after the third byte, then a fresh 4-byte dump.
    snapshot();
    applyStimulus((INSTRW+1)'(8));
    seen = 0;
    waited = 0;
    while (seen < 3 && waited < 100) begin
      @(negedge clk);
      waited++;
      if (txWrEn) seen++;
    end
    checkOutput("rst third_byte_seen", seen, 3);
    rstB = 1'b0;
    @(posedge clk);
    #1;
    rstB = 1'b1;
    @(negedge clk);
    checkOutput("midrst memAddr", int'(memAddr), 0);
    checkOutput("midrst memRdEn", int'(memRdEn), 0);
    checkOutput("midrst txWrEn", int'(txWrEn), 0);
    checkOutput("midrst txData", int'(txData), 0);
    checkOutput("midrst busy", int'(busy), 0);
    checkOutput("midrst done", int'(done), 0);
    checkOutput("midrst bytes_sent", got_q.size() - base_got, 3);
    build_expected(4);
    snapshot();
    applyStimulus((INSTRW+1)'(4));
    finish_dump("after_rst", 200);

    for (int i = 0; i < NWORDS; i++) ram[i] = $urandom;
    for (int r = 0; r < 6; r++) begin
      rlen = $urandom_range(1, 48);
      full_mode = $urandom_range(0, 2);
      build_expected(rlen);
      snapshot();
      applyStimulus((INSTRW+1)'(rlen));
      finish_dump($sformatf("rand%0d len%0d mode%0d", r, rlen, full_mode), 8 * rlen + 100);
    end
    full_mode = 0;

    // Oversized request clamps to the whole memory, ending on a 3-byte partial word.
    build_expected(65535);
    snapshot();
    applyStimulus('1);
    finish_dump("clamp", 3 * MEM_SIZE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
